// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display capture path.
package display_pkg;

  // Segment patterns, a..g mapped onto bits [6:0]
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LATCH  = 2'd2
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] nibble;
  } seg_dec_t;

  // Maps a segment pattern to {ok, nibble}; unknown patterns give {0, 0}
  function automatic seg_dec_t seg_to_nibble(input logic [6:0] s);
    seg_dec_t r;
    r.ok     = 1'b1;
    r.nibble = 4'h0;
    case (s)
      SEG_0:   r.nibble = 4'h0;
      SEG_1:   r.nibble = 4'h1;
      SEG_2:   r.nibble = 4'h2;
      SEG_3:   r.nibble = 4'h3;
      SEG_4:   r.nibble = 4'h4;
      SEG_5:   r.nibble = 4'h5;
      SEG_6:   r.nibble = 4'h6;
      SEG_7:   r.nibble = 4'h7;
      SEG_8:   r.nibble = 4'h8;
      SEG_9:   r.nibble = 4'h9;
      SEG_A:   r.nibble = 4'hA;
      SEG_B:   r.nibble = 4'hB;
      SEG_C:   r.nibble = 4'hC;
      SEG_D:   r.nibble = 4'hD;
      SEG_E:   r.nibble = 4'hE;
      SEG_F:   r.nibble = 4'hF;
      default: r.ok     = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational decode of one seven-segment digit (plus dp) to a hex nibble.
module seg_decoder
  import display_pkg::*;
(
  input  logic [7:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_dp,
  output logic       o_ok
);

  seg_dec_t w_dec;

  // Table lookup on a..g, dp passes straight through
  always_comb begin
    w_dec    = seg_to_nibble(i_seg[6:0]);
    o_nibble = w_dec.nibble;
    o_ok     = w_dec.ok;
    o_dp     = i_seg[7];
  end

endmodule

// File: rtl/display_capture.sv
// Receive side of the multiplexed 8-digit display bus: settles, decodes and
// assembles the 32-bit word currently being scanned out.
module display_capture
  import display_pkg::*;
#(
  parameter int unsigned SETTLE         = 4,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  which,
  input  logic [7:0]  seg,
  output logic [31:0] data_out,
  output logic [7:0]  dp_out,
  output logic        valid,
  output logic        changed,
  output logic        err,
  output logic        timeout
);

  localparam logic [7:0] LP_SETTLE = 8'(SETTLE);

  logic [2:0]           r_which;
  logic [7:0]           r_seg;
  logic [2:0]           r_which_d;
  logic [7:0]           r_seg_d;
  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [31:0]          r_shadow;
  logic [7:0]           r_shadow_dp;
  logic [7:0]           r_mask;
  logic                 r_ferr;
  logic [TIMEOUT_W-1:0] r_tcnt;
  logic [31:0]          r_data_out;
  logic [7:0]           r_dp_out;
  logic                 r_valid;
  logic                 r_changed;
  logic                 r_err;
  logic                 r_timeout;

  logic [7:0] w_seg_in;
  logic       w_chg;
  logic       w_latch;
  logic       w_complete;
  logic       w_tmo_hit;
  logic [3:0] w_nib;
  logic       w_dp;
  logic       w_ok;
  logic [7:0] w_mask_base;
  logic       w_ferr_base;

  assign w_seg_in = SEG_ACTIVE_LOW ? ~seg : seg;

  // Input stage plus a delayed copy used only for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_which   <= '0;
      r_seg     <= '0;
      r_which_d <= '0;
      r_seg_d   <= '0;
    end else begin
      r_which   <= which;
      r_seg     <= w_seg_in;
      r_which_d <= r_which;
      r_seg_d   <= r_seg;
    end
  end

  assign w_chg = ({r_which, r_seg} != {r_which_d, r_seg_d});

  seg_decoder u_dec (
    .i_seg    (r_seg),
    .o_nibble (w_nib),
    .o_dp     (w_dp),
    .o_ok     (w_ok)
  );

  // Settle FSM: a digit is latched once after holding SETTLE cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_chg) begin
            r_state <= ST_SETTLE;
            r_cnt   <= 8'd1;
          end
        end
        ST_SETTLE: begin
          if (w_chg) begin
            r_cnt <= 8'd1;
          end else if (r_cnt >= LP_SETTLE) begin
            r_state <= ST_LATCH;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_LATCH: begin
          if (w_chg) begin
            r_state <= ST_SETTLE;
            r_cnt   <= 8'd1;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_latch    = (r_state == ST_LATCH);
  assign w_complete = (r_mask == 8'hFF);
  assign w_tmo_hit  = (r_mask != 8'h00) && !w_complete && (r_tcnt == '1);

  // Completion and timeout both restart the frame; a digit latched in that
  // same cycle still lands in the fresh mask so it is not lost.
  always_comb begin
    w_mask_base = (w_complete || w_tmo_hit) ? 8'h00 : r_mask;
    w_ferr_base = (w_complete || w_tmo_hit) ? 1'b0 : r_ferr;
  end

  // Shadow word, mask and per-frame error accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_mask      <= '0;
      r_ferr      <= 1'b0;
    end else begin
      if (w_latch) begin
        r_shadow[{r_which, 2'b00} +: 4] <= w_nib;
        r_shadow_dp[r_which]            <= w_dp;
        r_mask <= w_mask_base | (8'b1 << r_which);
        r_ferr <= w_ferr_base | ~w_ok;
      end else begin
        r_mask <= w_mask_base;
        r_ferr <= w_ferr_base;
      end
    end
  end

  // Frame timeout counter, running only while a frame is partly captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (w_complete || w_tmo_hit || (r_mask == 8'h00)) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // Output registers and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_dp_out   <= '0;
      r_valid    <= 1'b0;
      r_changed  <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid   <= w_complete;
      r_changed <= w_complete && (r_shadow != r_data_out);
      r_err     <= w_complete && r_ferr;
      r_timeout <= w_tmo_hit;
      if (w_complete) begin
        r_data_out <= r_shadow;
        r_dp_out   <= r_shadow_dp;
      end
    end
  end

  assign data_out = r_data_out;
  assign dp_out   = r_dp_out;
  assign valid    = r_valid;
  assign changed  = r_changed;
  assign err      = r_err;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture: stimulus pushes expected frame or
// timeout events, an independent monitor pops and compares them.
module tb_display_capture;

  logic        clk;
  logic        rst_n;
  logic [2:0]  which;
  logic [7:0]  seg;
  logic [31:0] data_out;
  logic [7:0]  dp_out;
  logic        valid;
  logic        changed;
  logic        err;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_tmo;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        chg;
    logic        err;
  } exp_t;

  exp_t q[$];

  display_capture #(
    .SETTLE         (4),
    .TIMEOUT_W      (8),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .which    (which),
    .seg      (seg),
    .data_out (data_out),
    .dp_out   (dp_out),
    .valid    (valid),
    .changed  (changed),
    .err      (err),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;
      4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;
      4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;
      4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp,
                            input logic c, input logic e);
    exp_t x;
    x.is_tmo = 1'b0; x.data = d; x.dp = dp; x.chg = c; x.err = e;
    q.push_back(x);
  endtask

  task automatic push_tmo(input logic [31:0] held);
    exp_t x;
    x.is_tmo = 1'b1; x.data = held; x.dp = '0; x.chg = 1'b0; x.err = 1'b0;
    q.push_back(x);
  endtask

  // Drive ndig digits, each held 20 cycles; bad_pos shows 8'h00,
  // glitch_pos first shows 7F for 2 cycles.
  task automatic send_frame(input logic [31:0] w, input logic [7:0] dp,
                            input int unsigned bad_pos, input int unsigned glitch_pos,
                            input int unsigned ndig);
    logic [3:0] n;
    for (int unsigned i = 0; i < ndig; i++) begin
      n = w[i*4 +: 4];
      if (i == glitch_pos) begin
        @(posedge clk); #1;
        which = 3'(i);
        seg   = 8'h7F;
        repeat (1) @(posedge clk);
      end
      @(posedge clk); #1;
      which = 3'(i);
      seg   = (i == bad_pos) ? 8'h00 : {dp[i], pat(n)};
      repeat (19) @(posedge clk);
    end
  endtask

  // Monitor: every valid or timeout pulse must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (valid || timeout)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event valid=%0b timeout=%0b data_out=%h", valid, timeout, data_out);
      end else begin
        e = q.pop_front();
        chk("event_kind_timeout", {31'd0, timeout}, {31'd0, e.is_tmo});
        chk("event_kind_valid", {31'd0, valid}, {31'd0, ~e.is_tmo});
        chk("data_out", data_out, e.data);
        if (!e.is_tmo) begin
          chk("dp_out", {24'd0, dp_out}, {24'd0, e.dp});
          chk("changed", {31'd0, changed}, {31'd0, e.chg});
          chk("err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_expired pending=%0d", q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    which = '0;
    seg   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_dp_out", {24'd0, dp_out}, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'h0);
    chk("rst_changed", {31'd0, changed}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    chk("rst_timeout", {31'd0, timeout}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    push_frame(32'hFEDCBA98, 8'hA5, 1'b1, 1'b0);
    send_frame(32'hFEDCBA98, 8'hA5, 8, 8, 8);

    push_frame(32'h76543210, 8'h00, 1'b1, 1'b0);
    send_frame(32'h76543210, 8'h00, 8, 8, 8);

    push_frame(32'h76543210, 8'h00, 1'b0, 1'b0);
    send_frame(32'h76543210, 8'h00, 8, 8, 8);

    // digit 3 glitches through 8 before settling on 1
    push_frame(32'hFEDC1A98, 8'h00, 1'b1, 1'b0);
    send_frame(32'hFEDC1A98, 8'h00, 8, 3, 8);

    // digit 5 undecodable
    push_frame(32'h76043210, 8'h00, 1'b1, 1'b1);
    send_frame(32'h76543210, 8'h00, 5, 8, 8);

    push_frame(32'h76543210, 8'h00, 1'b1, 1'b0);
    send_frame(32'h76543210, 8'h00, 8, 8, 8);

    // partial frame then silence: timeout, data_out held
    push_tmo(32'h76543210);
    send_frame(32'h0000ABCD, 8'h00, 8, 8, 4);
    repeat (260) @(posedge clk);

    push_frame(32'hCAFE0123, 8'h3C, 1'b1, 1'b0);
    send_frame(32'hCAFE0123, 8'h3C, 8, 8, 8);

    // reset in the middle of a frame
    send_frame(32'h89ABCDEF, 8'h00, 8, 8, 4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", data_out, 32'h0);
    chk("midrst_dp_out", {24'd0, dp_out}, 32'h0);
    chk("midrst_valid", {31'd0, valid}, 32'h0);
    chk("midrst_changed", {31'd0, changed}, 32'h0);
    chk("midrst_err", {31'd0, err}, 32'h0);
    chk("midrst_timeout", {31'd0, timeout}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    push_frame(32'h12345678, 8'h00, 1'b1, 1'b0);
    send_frame(32'h12345678, 8'h00, 8, 8, 8);
    repeat (10) @(posedge clk);

    chk("pending_events", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
